// File: rtl/hack_kbd_queue_if.sv
// Keyboard front-end bus: event strobes and CPU-side controls in, KBD value and status out.
interface hack_kbd_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          ev_valid;
  logic [7:0]    ev_code;
  logic          ev_break;
  logic          mode;
  logic          rd_ack;
  logic          clr_ovf;
  logic [15:0]   kbd_out;
  logic [CW-1:0] count;
  logic          overflow;

  modport master (
    output ev_valid, ev_code, ev_break, mode, rd_ack, clr_ovf,
    input  kbd_out, count, overflow
  );

  modport slave (
    input  ev_valid, ev_code, ev_break, mode, rd_ack, clr_ovf,
    output kbd_out, count, overflow
  );
endinterface

// File: rtl/hack_kbd_queue.sv
// Buffered Hack keyboard: held-key register, event FIFO and legacy/queued read mode.
// Optional typematic auto-repeat is compiled in when HACK_KBD_TYPEMATIC_EN is defined.
module hack_kbd_queue #(
  parameter int DEPTH        = 4,
  parameter int REPEAT_DELAY = 500000,
  parameter int REPEAT_RATE  = 100000
) (
  input  logic          clk,
  input  logic          reset,
  hack_kbd_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("hack_kbd_queue: illegal parameter set");
  end

  logic [7:0]    mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;
  logic [7:0]    held_r;
  logic          mode_prev_r;
  logic [7:0]    kbd_lo_r;

  logic          mode_chg_s, make_s, auto_push_s;
  logic [7:0]    held_nxt_s, push_data_s, head_s, kbd_nxt_s;
  logic [PW-1:0] wr_base_s, rd_base_s, wr_nxt_s, rd_nxt_s;
  logic [CW-1:0] cnt_base_s, cnt_nxt_s, remain_s;
  logic          push_req_s, pop_s, full_s, push_ok_s, drop_s, overflow_nxt_s;

  // Held-key tracking and mode-change detection
  always_comb begin
    mode_chg_s = (bus.mode != mode_prev_r);
    make_s     = bus.ev_valid & ~bus.ev_break;
    held_nxt_s = held_r;
    if (make_s) begin
      held_nxt_s = bus.ev_code;
    end else if (bus.ev_valid && (bus.ev_code == held_r)) begin
      held_nxt_s = 8'h00;
    end else begin
      held_nxt_s = held_r;
    end
  end

`ifdef HACK_KBD_TYPEMATIC_EN
  localparam int TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [1:0] {TM_IDLE = 2'd0, TM_DELAY = 2'd1, TM_REPEAT = 2'd2} tm_state_e;

  tm_state_e     tm_state_r, tm_state_nxt_s;
  logic [TW-1:0] tm_cnt_r, tm_cnt_nxt_s;

  // Typematic state and interval counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tm_state_r <= TM_IDLE;
      tm_cnt_r   <= '0;
    end else begin
      tm_state_r <= tm_state_nxt_s;
      tm_cnt_r   <= tm_cnt_nxt_s;
    end
  end

  // A fresh make restarts the delay and wins over any auto-push on the same edge
  always_comb begin
    tm_state_nxt_s = tm_state_r;
    tm_cnt_nxt_s   = tm_cnt_r;
    auto_push_s    = 1'b0;
    if (make_s && bus.mode) begin
      tm_state_nxt_s = TM_DELAY;
      tm_cnt_nxt_s   = '0;
    end else if (mode_chg_s || !bus.mode || (held_nxt_s == 8'h00)) begin
      tm_state_nxt_s = TM_IDLE;
      tm_cnt_nxt_s   = '0;
    end else begin
      case (tm_state_r)
        TM_IDLE: begin
          tm_state_nxt_s = TM_IDLE;
        end
        TM_DELAY: begin
          if (tm_cnt_r == TW'(REPEAT_DELAY - 1)) begin
            auto_push_s    = 1'b1;
            tm_state_nxt_s = TM_REPEAT;
            tm_cnt_nxt_s   = '0;
          end else begin
            tm_cnt_nxt_s = tm_cnt_r + TW'(1);
          end
        end
        TM_REPEAT: begin
          if (tm_cnt_r == TW'(REPEAT_RATE - 1)) begin
            auto_push_s  = 1'b1;
            tm_cnt_nxt_s = '0;
          end else begin
            tm_cnt_nxt_s = tm_cnt_r + TW'(1);
          end
        end
        default: begin
          tm_state_nxt_s = TM_IDLE;
          tm_cnt_nxt_s   = '0;
        end
      endcase
    end
  end
`else
  assign auto_push_s = 1'b0;
`endif

  // FIFO next state; a mode change flushes before this edge's event is applied
  always_comb begin
    wr_base_s   = mode_chg_s ? '0 : wr_ptr_r;
    rd_base_s   = mode_chg_s ? '0 : rd_ptr_r;
    cnt_base_s  = mode_chg_s ? '0 : count_r;
    push_req_s  = bus.mode & (make_s | auto_push_s);
    push_data_s = make_s ? bus.ev_code : held_r;
    pop_s       = bus.mode & bus.rd_ack & (cnt_base_s != '0);
    full_s      = (cnt_base_s == FULL_CNT);
    push_ok_s   = push_req_s & (~full_s | pop_s);
    drop_s      = push_req_s & full_s & ~pop_s;
    wr_nxt_s    = push_ok_s ? wr_base_s + PW'(1) : wr_base_s;
    rd_nxt_s    = pop_s ? rd_base_s + PW'(1) : rd_base_s;
    remain_s    = pop_s ? cnt_base_s - CW'(1) : cnt_base_s;
    if (push_ok_s && !pop_s) begin
      cnt_nxt_s = cnt_base_s + CW'(1);
    end else if (pop_s && !push_ok_s) begin
      cnt_nxt_s = cnt_base_s - CW'(1);
    end else begin
      cnt_nxt_s = cnt_base_s;
    end
    if (drop_s) begin
      overflow_nxt_s = 1'b1;
    end else if (bus.clr_ovf) begin
      overflow_nxt_s = 1'b0;
    end else begin
      overflow_nxt_s = overflow_r;
    end
    // Head after this edge: the just-written byte if it is the only entry left
    if (cnt_nxt_s == '0) begin
      head_s = 8'h00;
    end else if (remain_s == '0) begin
      head_s = push_data_s;
    end else begin
      head_s = mem_r[rd_nxt_s];
    end
    kbd_nxt_s = bus.mode ? head_s : held_nxt_s;
  end

  // State registers and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      held_r      <= 8'h00;
      mode_prev_r <= 1'b0;
      kbd_lo_r    <= 8'h00;
    end else begin
      if (push_ok_s) begin
        mem_r[wr_base_s] <= push_data_s;
      end
      wr_ptr_r    <= wr_nxt_s;
      rd_ptr_r    <= rd_nxt_s;
      count_r     <= cnt_nxt_s;
      overflow_r  <= overflow_nxt_s;
      held_r      <= held_nxt_s;
      mode_prev_r <= bus.mode;
      kbd_lo_r    <= kbd_nxt_s;
    end
  end

  assign bus.kbd_out  = {8'h00, kbd_lo_r};
  assign bus.count    = count_r;
  assign bus.overflow = overflow_r;
endmodule

// File: tb/tb_hack_kbd_queue.sv
// Self-checking bench for hack_kbd_queue: queue-based reference model, per-cycle compare, directed and random traffic.
module tb_hack_kbd_queue;
  localparam int DEPTH = 4;
  localparam int RD    = 8;
  localparam int RR    = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  hack_kbd_queue_if #(.DEPTH(DEPTH)) bus ();

  hack_kbd_queue #(.DEPTH(DEPTH), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  // Reference model state
  logic [7:0]  m_q[$];
  logic [7:0]  m_held;
  bit          m_ov, m_mode_prev, m_tm_active;
  int          m_age;
  logic [15:0] exp_kbd;
  int          exp_cnt;
  bit          exp_ov;

  task automatic model_step();
    bit make, auto_p, push, pop;
    logic [7:0] held_new, data;
    if (bus.mode != m_mode_prev) begin
      m_q.delete();
      m_tm_active = 1'b0;
    end
    make = bus.ev_valid && !bus.ev_break;
    held_new = m_held;
    if (make) held_new = bus.ev_code;
    else if (bus.ev_valid && bus.ev_code == m_held) held_new = 8'h00;
    auto_p = 1'b0;
`ifdef HACK_KBD_TYPEMATIC_EN
    if (make && bus.mode) begin
      m_tm_active = 1'b1;
      m_age = 0;
    end else if (!bus.mode || bus.mode != m_mode_prev || held_new == 8'h00) begin
      m_tm_active = 1'b0;
    end else if (m_tm_active) begin
      m_age++;
      if (m_age == RD || (m_age > RD && ((m_age - RD) % RR) == 0)) auto_p = 1'b1;
    end
`endif
    push = bus.mode && (make || auto_p);
    data = make ? bus.ev_code : m_held;
    pop  = bus.mode && bus.rd_ack && (m_q.size() > 0);
    if (pop) void'(m_q.pop_front());
    if (bus.clr_ovf) m_ov = 1'b0;
    if (push) begin
      if (m_q.size() < DEPTH) m_q.push_back(data);
      else m_ov = 1'b1;
    end
    m_held = held_new;
    m_mode_prev = bus.mode;
  endtask

  // Model tracks the DUT edge by edge and resets asynchronously with it
  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_q.delete();
        m_held = 8'h00;
        m_ov = 1'b0;
        m_mode_prev = 1'b0;
        m_tm_active = 1'b0;
        m_age = 0;
      end else begin
        model_step();
      end
      exp_cnt = m_q.size();
      exp_ov  = m_ov;
      if (m_mode_prev) exp_kbd = (m_q.size() > 0) ? {8'h00, m_q[0]} : 16'h0000;
      else             exp_kbd = {8'h00, m_held};
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      n_tests++;
      if (bus.kbd_out !== exp_kbd || bus.count !== exp_cnt[2:0] || bus.overflow !== exp_ov) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t kbd=%h exp=%h count=%0d exp=%0d ovf=%b exp=%b",
                 $time, bus.kbd_out, exp_kbd, bus.count, exp_cnt, bus.overflow, exp_ov);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input logic v, input logic [7:0] code, input logic b, input logic r, input logic c);
    bus.ev_valid = v;
    bus.ev_code  = code;
    bus.ev_break = b;
    bus.rd_ack   = r;
    bus.clr_ovf  = c;
    @(posedge clk);
    @(negedge clk);
    #1;
    bus.ev_valid = 1'b0;
    bus.ev_break = 1'b0;
    bus.rd_ack   = 1'b0;
    bus.clr_ovf  = 1'b0;
  endtask

  task automatic make_key(input logic [7:0] code);
    cyc(1'b1, code, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic break_key(input logic [7:0] code);
    cyc(1'b1, code, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] exp_seq [4];
    bus.ev_valid = 1'b0;
    bus.ev_code  = 8'h00;
    bus.ev_break = 1'b0;
    bus.mode     = 1'b0;
    bus.rd_ack   = 1'b0;
    bus.clr_ovf  = 1'b0;
    #2;
    chk("reset_kbd", {16'h0, bus.kbd_out}, 32'h0);
    chk("reset_count", {29'h0, bus.count}, 32'h0);
    chk("reset_ovf", {31'h0, bus.overflow}, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    reset = 1'b1;
    check_en = 1'b1;

    // Legacy held-key behaviour
    make_key(8'h41);  chk("legacy_make41", {16'h0, bus.kbd_out}, 32'h0041);
    make_key(8'h42);  chk("legacy_make42", {16'h0, bus.kbd_out}, 32'h0042);
    break_key(8'h41); chk("legacy_brk41", {16'h0, bus.kbd_out}, 32'h0042);
    break_key(8'h42); chk("legacy_brk42", {16'h0, bus.kbd_out}, 32'h0000);

    // Queued mode with overflow
    bus.mode = 1'b1;
    idle(1);
    for (int k = 0; k < 5; k++) make_key(8'h41 + 8'(k));
    chk("q_full_count", {29'h0, bus.count}, 32'd4);
    chk("q_full_ovf", {31'h0, bus.overflow}, 32'd1);
    chk("q_full_head", {16'h0, bus.kbd_out}, 32'h0041);
    break_key(8'h45);
    exp_seq[0] = 8'h42; exp_seq[1] = 8'h43; exp_seq[2] = 8'h44; exp_seq[3] = 8'h00;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      chk("q_pop_head", {16'h0, bus.kbd_out}, {24'h0, exp_seq[k]});
    end
    chk("q_empty_count", {29'h0, bus.count}, 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("q_pop_empty_kbd", {16'h0, bus.kbd_out}, 32'h0);
    chk("q_pop_empty_count", {29'h0, bus.count}, 32'd0);
    chk("q_ovf_sticky", {31'h0, bus.overflow}, 32'd1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("q_clr_ovf", {31'h0, bus.overflow}, 32'd0);

    // Simultaneous push and pop: full, then empty
    for (int k = 0; k < 4; k++) make_key(8'h11 + 8'(k));
    break_key(8'h14);
    cyc(1'b1, 8'h50, 1'b0, 1'b1, 1'b0);
    chk("sim_full_count", {29'h0, bus.count}, 32'd4);
    chk("sim_full_ovf", {31'h0, bus.overflow}, 32'd0);
    chk("sim_full_head", {16'h0, bus.kbd_out}, 32'h0012);
    break_key(8'h50);
    for (int k = 0; k < 3; k++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("sim_last_is_50", {16'h0, bus.kbd_out}, 32'h0050);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 8'h60, 1'b0, 1'b1, 1'b0);
    chk("sim_empty_count", {29'h0, bus.count}, 32'd1);
    chk("sim_empty_head", {16'h0, bus.kbd_out}, 32'h0060);
    break_key(8'h60);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Mode switch flushes the FIFO and shows the held key
    make_key(8'h21); make_key(8'h22); make_key(8'h23);
    chk("msw_count3", {29'h0, bus.count}, 32'd3);
    bus.mode = 1'b0;
    idle(1);
    chk("msw_count0", {29'h0, bus.count}, 32'd0);
    chk("msw_kbd_held", {16'h0, bus.kbd_out}, 32'h0023);
    break_key(8'h23);

    // Typematic: make at edge 0, break at edge 14
    bus.mode = 1'b1;
    idle(1);
    make_key(8'h80);
    idle(13);
    break_key(8'h80);
    idle(6);
`ifdef HACK_KBD_TYPEMATIC_EN
    chk("tm_count", {29'h0, bus.count}, 32'd3);
`else
    chk("tm_count", {29'h0, bus.count}, 32'd1);
`endif
    chk("tm_head", {16'h0, bus.kbd_out}, 32'h0080);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic v, b, r, c;
      logic [7:0] code;
      if ($urandom_range(0, 99) == 0) bus.mode = ~bus.mode;
      v = ($urandom_range(0, 3) == 0);
      b = v && ($urandom_range(0, 1) == 1);
      code = (b && $urandom_range(0, 1) == 1) ? m_held : 8'($urandom_range(1, 8));
      r = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 15) == 0);
      cyc(v, code, b, r, c);
    end

    // Async reset mid-traffic, checked before any clock edge
    bus.mode = 1'b1;
    for (int k = 0; k < 5; k++) make_key(8'h31 + 8'(k));
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("areset_kbd", {16'h0, bus.kbd_out}, 32'h0);
    chk("areset_count", {29'h0, bus.count}, 32'h0);
    chk("areset_ovf", {31'h0, bus.overflow}, 32'h0);
    bus.mode = 1'b0;
    @(negedge clk);
    #1;
    reset = 1'b1;
    idle(3);
    chk("post_reset_kbd", {16'h0, bus.kbd_out}, 32'h0);
    chk("post_reset_count", {29'h0, bus.count}, 32'h0);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
